// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/FIFO-side bundle of the UART TX write-port arbiter
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               fifo_full;
    logic               fifo_wr_en;
    logic [7:0]         fifo_wr_data;
    logic [2:0]         grant_id;
    logic               busy;
    logic               forced_rel;
    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, forced_rel
    );
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, forced_rel
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of the UART TX FIFO write port
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int IDLE_TMO  = 64
) (
    input logic clk,
    input logic reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 255 ||
        IDLE_TMO < 1 || IDLE_TMO > 1023) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state;
    logic [IW-1:0] g, lg, nxt, idx;
    logic [7:0]    byte_cnt;
    logic [9:0]    tmo_cnt;
    logic          busy_q, fr_q;
    logic          xfer, done_last, burst_hit, tmo_hit;
    logic [7:0]    bytes [N_REQ];
    genvar i;
    for (i = 0; i < N_REQ; i++) begin : g_bytes
        assign bytes[i] = bus.req_data[8*i +: 8];
    end
    // Scan from farthest to nearest so the first valid after last_grant wins.
    always_comb begin
        nxt = lg;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(lg) + k) % N_REQ);
            nxt = bus.req_valid[idx] ? idx : nxt;
        end
    end
    assign xfer      = state == GRANT && bus.req_valid[g] && !bus.fifo_full;
    assign done_last = xfer && bus.req_last[g];
    assign burst_hit = xfer && !bus.req_last[g] && byte_cnt == 8'(MAX_BURST - 1);
    assign tmo_hit   = state == GRANT && !xfer && tmo_cnt == 10'(IDLE_TMO - 1);
    assign bus.req_ready    = (state == GRANT && !bus.fifo_full) ? N_REQ'(1) << g : '0;
    assign bus.fifo_wr_en   = xfer;
    assign bus.fifo_wr_data = xfer ? bytes[g] : 8'd0;
    assign bus.grant_id     = 3'(g);
    assign bus.busy         = busy_q;
    assign bus.forced_rel   = fr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lg       <= IW'(N_REQ - 1);
            g        <= '0;
            busy_q   <= 1'b0;
            fr_q     <= 1'b0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            fr_q <= 1'b0;
            if (state == IDLE) begin
                if (|bus.req_valid) begin
                    state    <= GRANT;
                    busy_q   <= 1'b1;
                    g        <= nxt;
                    byte_cnt <= '0;
                    tmo_cnt  <= '0;
                end
            end else begin
                byte_cnt <= xfer ? byte_cnt + 8'd1 : byte_cnt;
                tmo_cnt  <= xfer ? 10'd0 : (&tmo_cnt ? tmo_cnt : tmo_cnt + 10'd1);
                if (done_last || burst_hit || tmo_hit) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    lg     <= g;
                    fr_q   <= !done_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, throttling, burst/idle release and reset
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    uart_tx_arbiter_if #(.N_REQ(4)) bus();
    uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(16), .IDLE_TMO(64)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    int total = 0, bad = 0, cyc = 0, fr_cnt = 0, fr_cyc = 0, viol;
    logic [8:0] q [4][$];
    logic [7:0] wr_log [$];
    logic [2:0] gnt_log [$];
    int wr_cyc [$];
    logic [3:0] en = 4'hf;
    logic stall = 1'b0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < 4; i++) begin
            h = q[i].size() > 0 ? q[i][0] : 9'h000;
            bus.req_valid[i] = en[i] && q[i].size() > 0;
            bus.req_data[8*i +: 8] = h[7:0];
            bus.req_last[i] = h[8];
        end
        bus.fifo_full = stall;
    endtask
    task automatic sample();
        cyc++;
        if (bus.fifo_wr_en) begin
            wr_log.push_back(bus.fifo_wr_data);
            gnt_log.push_back(bus.grant_id);
            wr_cyc.push_back(cyc);
        end
        if (bus.forced_rel) begin
            fr_cnt++;
            fr_cyc = cyc;
        end
        for (int i = 0; i < 4; i++)
            if (bus.req_ready[i] && bus.req_valid[i]) void'(q[i].pop_front());
    endtask
    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        sample();
    endtask
    task automatic run(input int n);
        repeat (n) tick();
    endtask
    task automatic clr_logs();
        wr_log.delete();
        gnt_log.delete();
        wr_cyc.delete();
        fr_cnt = 0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        en = 4'hf;
        stall = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clr_logs();
    endtask
    initial begin
        drive();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_wen", bus.fifo_wr_en, 0);
        chk("rst_wdata", bus.fifo_wr_data, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_frel", bus.forced_rel, 0);
        // 3-byte packet from requester 0
        do_reset();
        q[0] = '{9'h041, 9'h042, 9'h143};
        run(2);
        chk("t1_busy_hi", bus.busy, 1);
        run(3);
        chk("t1_busy_lo", bus.busy, 0);
        chk("t1_gid", bus.grant_id, 0);
        chk("t1_n", wr_log.size(), 3);
        for (int k = 0; k < 3; k++) chk($sformatf("t1_d%0d", k), wr_log[k], 32'h41 + k);
        chk("t1_consec", wr_cyc[2] - wr_cyc[0], 2);
        // all four requesting single-byte packets
        do_reset();
        q[0] = '{9'h1a0, 9'h1a4};
        q[1] = '{9'h1a1};
        q[2] = '{9'h1a2};
        q[3] = '{9'h1a3};
        run(14);
        chk("t2_n", wr_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t2_d%0d", k), wr_log[k], 32'ha0 + k);
            chk($sformatf("t2_g%0d", k), gnt_log[k], k % 4);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("t2_gap%0d", k), wr_cyc[k+1] - wr_cyc[k], 2);
        // FIFO full stall mid-packet
        do_reset();
        q[1] = '{9'h010, 9'h011, 9'h012, 9'h113};
        run(3);
        stall = 1'b1;
        viol = 0;
        repeat (10) begin
            tick();
            if (bus.fifo_wr_en || bus.req_ready != 4'h0) viol++;
        end
        chk("t3_stall", viol, 0);
        stall = 1'b0;
        run(4);
        chk("t3_n", wr_log.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t3_d%0d", k), wr_log[k], 32'h10 + k);
        chk("t3_busy", bus.busy, 0);
        // burst limit on 20-byte packet from requester 2
        do_reset();
        for (int k = 0; k < 20; k++) q[2].push_back({1'b0, 8'(8'h20 + k)});
        q[3] = '{9'h199};
        run(26);
        chk("t4_n", wr_log.size(), 21);
        for (int k = 0; k < 16; k++) chk($sformatf("t4_d%0d", k), wr_log[k], 32'h20 + k);
        chk("t4_r3", wr_log[16], 8'h99);
        chk("t4_g3", gnt_log[16], 3);
        for (int k = 17; k < 21; k++) chk($sformatf("t4_d%0d", k), wr_log[k], 32'h30 + k - 17);
        chk("t4_g2", gnt_log[17], 2);
        chk("t4_frn", fr_cnt, 1);
        chk("t4_frc", fr_cyc - wr_cyc[15], 1);
        // idle timeout after requester 0 drops valid
        do_reset();
        q[0] = '{9'h050, 9'h051};
        q[1] = '{9'h161};
        run(2);
        en[0] = 1'b0;
        run(70);
        chk("t5_n", wr_log.size(), 2);
        chk("t5_d1", wr_log[1], 8'h61);
        chk("t5_g1", gnt_log[1], 1);
        chk("t5_frn", fr_cnt, 1);
        chk("t5_frc", fr_cyc - wr_cyc[0], 65);
        // async reset in the middle of a packet
        do_reset();
        q[0] = '{9'h170};
        q[1] = '{9'h080, 9'h081, 9'h182};
        run(4);
        q[0].push_back(9'h177);
        q[2].push_back(9'h192);
        @(negedge clk);
        drive();
        #1;
        chk("t6_pre", bus.fifo_wr_data, 8'h81);
        reset = 1'b1;
        #1;
        chk("t6_wen", bus.fifo_wr_en, 0);
        chk("t6_wdata", bus.fifo_wr_data, 0);
        chk("t6_ready", bus.req_ready, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_gid", bus.grant_id, 0);
        @(negedge clk);
        reset = 1'b0;
        clr_logs();
        run(9);
        chk("t6_n", wr_log.size(), 4);
        chk("t6_d0", wr_log[0], 8'h77);
        chk("t6_g0", gnt_log[0], 0);
        chk("t6_d3", wr_log[3], 8'h92);
        chk("t6_g3", gnt_log[3], 2);
        // last byte coincides with burst limit: normal end
        do_reset();
        for (int k = 0; k < 16; k++) q[0].push_back({k == 15, 8'(8'hc0 + k)});
        run(20);
        chk("t7_n", wr_log.size(), 16);
        chk("t7_frn", fr_cnt, 0);
        chk("t7_busy", bus.busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
